afe2256_init_sequencer: RTL and testbench

Upstream master for `afe2256_spi_controller`: on a start pulse, walks `INIT_SEQUENCE` from `afe2256_spi_pkg` and issues one register write per entry. Each write completes on the controller's `done`, followed by the entry's `delay_us` settle time. After the sequence finishes, arbitrates runtime host register writes onto the same controller port. Detects a controller that never answers (timeout) and reports the failing entry.

---
 rtl/afe2256_spi_pkg.sv | 36 +++
 rtl/afe2256_us_delay.sv | 44 ++++
 rtl/afe2256_init_sequencer.sv | 150 +++++++++++++++
 tb/tb_afe2256_init_sequencer.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/afe2256_spi_pkg.sv
// Shared AFE2256 register map, power-up write sequence and init-sequencer types.
package afe2256_spi_pkg;

  typedef struct packed {
    logic [7:0]  addr;
    logic [15:0] data;
    logic [15:0] delay_us;
  } init_reg_t;

  localparam logic [7:0] REG_RESET     = 8'h00;
  localparam logic [7:0] REG_TRIM_LOAD = 8'h5E;

  localparam int INIT_REG_COUNT = 6;
  localparam int INIT_IDX_W     = $clog2(INIT_REG_COUNT);

  // Soft reset and trim load need settle time before the next access.
  localparam init_reg_t INIT_SEQUENCE [INIT_REG_COUNT] = '{
    '{addr: REG_RESET,     data: 16'h0001, delay_us: 16'd10},
    '{addr: 8'h10,         data: 16'h0000, delay_us: 16'd0},
    '{addr: 8'h20,         data: 16'h1234, delay_us: 16'd1},
    '{addr: 8'h30,         data: 16'hABCD, delay_us: 16'd0},
    '{addr: REG_TRIM_LOAD, data: 16'h0002, delay_us: 16'd2},
    '{addr: 8'h40,         data: 16'h00FF, delay_us: 16'd0}
  };

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_DONE,
    DELAY,
    READY,
    HOST_WAIT,
    ERROR
  } init_state_t;

endpackage

// File: rtl/afe2256_us_delay.sv
// Microsecond settle timer: prescaler nested under a microsecond down-counter.
module afe2256_us_delay
  import afe2256_spi_pkg::*;
#(
  parameter int CLK_FREQ_MHZ = 100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] delay_us,
  output logic        expire
);

  localparam int PRE_W = $clog2(CLK_FREQ_MHZ + 1);

  logic             active;
  logic [PRE_W-1:0] pre;
  logic [15:0]      us;

  // Expires on the last cycle of delay_us * CLK_FREQ_MHZ cycles after load.
  assign expire = active && (pre == '0) && (us == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      active <= 1'b0;
      pre    <= '0;
      us     <= '0;
    end else if (load) begin
      active <= 1'b1;
      pre    <= PRE_W'(CLK_FREQ_MHZ - 1);
      us     <= delay_us - 16'd1;
    end else if (active) begin
      if (expire) begin
        active <= 1'b0;
      end else if (pre == '0) begin
        pre <= PRE_W'(CLK_FREQ_MHZ - 1);
        us  <= us - 16'd1;
      end else begin
        pre <= pre - 1'b1;
      end
    end
  end

endmodule

// File: rtl/afe2256_init_sequencer.sv
// Walks INIT_SEQUENCE into the SPI controller, then arbitrates host register writes.
module afe2256_init_sequencer
  import afe2256_spi_pkg::*;
#(
  parameter int CLK_FREQ_MHZ = 100,
  parameter int TIMEOUT_CYC  = 4096
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [7:0]            host_addr,
  input  logic [15:0]           host_wdata,
  input  logic                  host_wr,
  output logic                  host_ready,
  output logic [7:0]            reg_addr,
  output logic [15:0]           reg_wdata,
  output logic                  reg_wr,
  input  logic                  busy,
  input  logic                  done,
  output logic                  init_busy,
  output logic                  init_done,
  output logic                  init_err,
  output logic [INIT_IDX_W-1:0] err_idx,
  output logic [INIT_IDX_W-1:0] cur_idx
);

  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

  init_state_t           state, state_next;
  logic [TMO_W-1:0]      tmo_cnt;
  logic                  host_pulse;
  logic                  dly_load, dly_expire;
  logic                  issue_fire, tmo_hit, last_entry;
  logic                  restart, host_accept, advance, enter_err;
  logic [INIT_IDX_W-1:0] idx_next;
  logic [15:0]           cur_delay;

  assign cur_delay  = INIT_SEQUENCE[cur_idx].delay_us;
  assign last_entry = (cur_idx == INIT_IDX_W'(INIT_REG_COUNT - 1));
  assign idx_next   = cur_idx + 1'b1;
  assign tmo_hit    = (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));

  // reg_wr is decoded from state so a sampled start/done reaches the controller next cycle.
  assign issue_fire = (state == ISSUE) && !busy;
  assign reg_wr     = issue_fire || host_pulse;
  assign host_ready = (state == READY) && !busy;
  assign init_busy  = (state == ISSUE) || (state == WAIT_DONE) || (state == DELAY);

  afe2256_us_delay #(
    .CLK_FREQ_MHZ(CLK_FREQ_MHZ)
  ) u_us_delay (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (dly_load),
    .delay_us(cur_delay),
    .expire  (dly_expire)
  );

  always_comb begin
    state_next  = state;
    restart     = 1'b0;
    host_accept = 1'b0;
    advance     = 1'b0;
    dly_load    = 1'b0;
    enter_err   = 1'b0;
    case (state)
      IDLE:      if (start) restart = 1'b1;
      ISSUE:     if (!busy) state_next = WAIT_DONE;
      WAIT_DONE: begin
        // done takes priority over a coincident timeout.
        if (done) begin
          if (cur_delay != 16'd0) begin
            dly_load   = 1'b1;
            state_next = DELAY;
          end else begin
            advance = 1'b1;
          end
        end else if (tmo_hit) begin
          enter_err = 1'b1;
        end
      end
      DELAY:     if (dly_expire) advance = 1'b1;
      READY: begin
        if (start) begin
          restart = 1'b1;
        end else if (host_wr && host_ready) begin
          host_accept = 1'b1;
          state_next  = HOST_WAIT;
        end
      end
      HOST_WAIT: begin
        if (done) state_next = READY;
        else if (tmo_hit) enter_err = 1'b1;
      end
      ERROR:     if (start) restart = 1'b1;
      default:   state_next = IDLE;
    endcase
    if (restart) state_next = ISSUE;
    if (advance) state_next = last_entry ? READY : ISSUE;
    if (enter_err) state_next = ERROR;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      reg_addr   <= '0;
      reg_wdata  <= '0;
      host_pulse <= 1'b0;
      tmo_cnt    <= '0;
      init_done  <= 1'b0;
      init_err   <= 1'b0;
      err_idx    <= '0;
      cur_idx    <= '0;
    end else begin
      state      <= state_next;
      host_pulse <= host_accept;

      // Counter value equals cycles elapsed since the reg_wr cycle.
      if (host_accept) tmo_cnt <= '0;
      else if (issue_fire) tmo_cnt <= TMO_W'(1);
      else if ((state == WAIT_DONE) || (state == HOST_WAIT)) tmo_cnt <= tmo_cnt + 1'b1;

      if (restart) begin
        cur_idx   <= '0;
        init_done <= 1'b0;
        init_err  <= 1'b0;
        reg_addr  <= INIT_SEQUENCE[0].addr;
        reg_wdata <= INIT_SEQUENCE[0].data;
      end
      if (advance) begin
        if (last_entry) begin
          init_done <= 1'b1;
        end else begin
          cur_idx   <= idx_next;
          reg_addr  <= INIT_SEQUENCE[idx_next].addr;
          reg_wdata <= INIT_SEQUENCE[idx_next].data;
        end
      end
      if (host_accept) begin
        reg_addr  <= host_addr;
        reg_wdata <= host_wdata;
      end
      if (enter_err) begin
        init_err <= 1'b1;
        if (state == WAIT_DONE) err_idx <= cur_idx;
      end
    end
  end

endmodule

// File: tb/tb_afe2256_init_sequencer.sv
// Scoreboard bench for afe2256_init_sequencer with a stub SPI controller.
module tb_afe2256_init_sequencer;
  import afe2256_spi_pkg::*;

  localparam int FREQ     = 100;
  localparam int TMO      = 64;
  localparam int STUB_LAT = 4;

  logic                  clk = 1'b0;
  logic                  rst_n, start, host_wr, host_ready, reg_wr, busy, done;
  logic [7:0]            host_addr, reg_addr;
  logic [15:0]           host_wdata, reg_wdata;
  logic                  init_busy, init_done, init_err;
  logic [INIT_IDX_W-1:0] err_idx, cur_idx;

  afe2256_init_sequencer #(
    .CLK_FREQ_MHZ(FREQ),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .host_addr (host_addr),
    .host_wdata(host_wdata),
    .host_wr   (host_wr),
    .host_ready(host_ready),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_wr    (reg_wr),
    .busy      (busy),
    .done      (done),
    .init_busy (init_busy),
    .init_done (init_done),
    .init_err  (init_err),
    .err_idx   (err_idx),
    .cur_idx   (cur_idx)
  );

  always #5 clk = ~clk;

  // Expected power-up table, written out independently of the package.
  logic [7:0]  exp_addr [6] = '{8'h00, 8'h10, 8'h20, 8'h30, 8'h5E, 8'h40};
  logic [15:0] exp_data [6] = '{16'h0001, 16'h0000, 16'h1234, 16'hABCD, 16'h0002, 16'h00FF};
  int          exp_dly  [6] = '{10, 0, 1, 0, 2, 0};

  typedef struct {
    logic [23:0] frame;
    int          gap;
  } exp_t;
  exp_t sb[$];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int frames = 0;
  int last_done = 0;
  int hang_wr_cyc = 0;
  bit hang_en = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Stub controller: busy for STUB_LAT cycles, then done, unless told to hang on 0x30.
  int lat;
  bit hung;
  always @(posedge clk) begin
    done <= 1'b0;
    if (!rst_n) begin
      busy <= 1'b0;
      lat  <= 0;
      hung <= 1'b0;
    end else if (reg_wr) begin
      busy <= 1'b1;
      lat  <= STUB_LAT;
      hung <= hang_en && (reg_addr == 8'h30);
    end else if (busy) begin
      lat <= lat - 1;
      if (lat == 1) begin
        busy <= 1'b0;
        done <= !hung;
      end
    end
  end

  // Monitor: every reg_wr is popped against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (done) last_done = cyc;
      if (reg_wr) begin
        frames++;
        if (reg_addr == 8'h30) hang_wr_cyc = cyc;
        if (sb.size() == 0) begin
          check("frame_unexpected", {8'h0, reg_addr, reg_wdata}, 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          check("frame", {8'h0, reg_addr, reg_wdata}, {8'h0, e.frame});
          if (e.gap > 0) check("done_to_wr_gap", cyc - last_done, e.gap);
        end
      end
    end
  end

  task automatic push_init();
    for (int i = 0; i < 6; i++)
      sb.push_back('{{exp_addr[i], exp_data[i]}, (i == 0) ? -1 : 1 + exp_dly[i-1] * FREQ});
  endtask

  task automatic pulse_start(input bit fresh);
    if (fresh) frames = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (fresh) check("start_to_wr", reg_wr, 1);
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!(init_done && host_ready) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_ready_timeout"}, n < 5000, 1);
    check({tag, "_frames"}, frames, 6);
    check({tag, "_init_err"}, init_err, 0);
    check({tag, "_sb_left"}, sb.size(), 0);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_reg_wr"}, reg_wr, 0);
    check({tag, "_reg_addr"}, reg_addr, 0);
    check({tag, "_reg_wdata"}, reg_wdata, 0);
    check({tag, "_init_busy"}, init_busy, 0);
    check({tag, "_init_done"}, init_done, 0);
    check({tag, "_init_err"}, init_err, 0);
    check({tag, "_err_idx"}, err_idx, 0);
    check({tag, "_cur_idx"}, cur_idx, 0);
    check({tag, "_host_ready"}, host_ready, 0);
  endtask

  initial begin
    int  n;
    bit  low_ok;
    rst_n = 1'b0; start = 1'b0; host_wr = 1'b0; host_addr = '0; host_wdata = '0;
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Full sequence; a host write during init must be dropped.
    push_init();
    pulse_start(1'b1);
    repeat (20) @(negedge clk);
    check("host_ready_during_init", host_ready, 0);
    host_addr = 8'h77; host_wdata = 16'h7777; host_wr = 1'b1;
    @(negedge clk);
    host_wr = 1'b0;
    wait_ready("run1");

    // Runtime host write.
    host_addr = 8'h5C; host_wdata = 16'h4800; host_wr = 1'b1;
    sb.push_back('{24'h5C4800, -1});
    @(negedge clk);
    host_wr = 1'b0;
    check("host_wr_pulse", reg_wr, 1);
    n = 0; low_ok = 1'b1;
    while (!done && n < 100) begin
      if (host_ready) low_ok = 1'b0;
      @(negedge clk);
      n++;
    end
    check("host_done_timeout", n < 100, 1);
    check("host_ready_low_until_done", low_ok, 1);
    @(negedge clk);
    check("host_ready_back", host_ready, 1);
    check("host_sb_left", sb.size(), 0);

    // Restart from READY; a second start at entry 2 is ignored.
    push_init();
    pulse_start(1'b1);
    n = 0;
    while (cur_idx != 2 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("reach_idx2_timeout", n < 3000, 1);
    pulse_start(1'b0);
    wait_ready("run2");

    // Controller never answers entry 3.
    hang_en = 1'b1;
    push_init();
    pulse_start(1'b1);
    n = 0;
    while (!init_err && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("hang_err_timeout", n < 5000, 1);
    check("hang_err_latency", cyc - hang_wr_cyc, TMO);
    check("hang_err_idx", err_idx, 3);
    check("hang_init_done", init_done, 0);
    check("hang_init_busy", init_busy, 0);
    check("hang_host_ready", host_ready, 0);
    sb.delete();
    hang_en = 1'b0;
    repeat (10) @(negedge clk);

    // Restart from ERROR.
    push_init();
    pulse_start(1'b1);
    wait_ready("run3");

    // Reset pulse during the first settle delay, then a clean rerun.
    push_init();
    pulse_start(1'b1);
    repeat (STUB_LAT + 10) @(negedge clk);
    check("pre_reset_init_busy", init_busy, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset("mid_reset");
    rst_n = 1'b1;
    sb.delete();
    @(negedge clk);
    push_init();
    pulse_start(1'b1);
    wait_ready("run4");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
